// File: rtl/alu_issue_wb.sv
// alu_issue_wb: three-state issue/writeback sequencer around an external ALU.
// It holds a 32x32 register file plus HI/LO. An accepted MIPS word is sent
// to the ALU together with its RF[rs]/RF[rt] operands, and the ALU results
// are routed back to RF, HI/LO or nowhere, depending on the decoded class.
module alu_issue_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_gr1,
  output logic [31:0] alu_gr2,
  input  logic [31:0] alu_c,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_waddr,
  input  logic [31:0] dbg_wdata,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        done,
  output logic        ovf_trap,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t      state_reg, state_next;
  logic [31:0] rf [32];

  // Decode fields of the word currently held for the ALU.
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  assign opcode = alu_instr[31:26];
  assign rs     = alu_instr[25:21];
  assign rt     = alu_instr[20:16];
  assign rd     = alu_instr[15:11];
  assign funct  = alu_instr[5:0];

  // Source-operand fields of the incoming word; they are read at the accept edge.
  logic [4:0]  in_rs, in_rt;
  assign in_rs = instr[25:21];
  assign in_rt = instr[20:16];

  logic        accept, dbg_wr_ok;
  assign accept    = (state_reg == IDLE) && instr_valid;
  assign dbg_wr_ok = (state_reg == IDLE) && dbg_we && (dbg_waddr != 5'd0);

  // Flag inputs that play no part in routing decisions.
  logic        unused_flags;
  assign unused_flags = alu_zero ^ alu_negative;

  logic        is_hilo, is_rd_wr, is_rt_wr, is_nowr, is_legal, ovf_chk, trap;
  logic        rf_we;
  logic [4:0]  rf_waddr;

  // Instruction classification and the writeback decision.
  always_comb begin
    is_hilo  = 1'b0;
    is_rd_wr = 1'b0;
    is_rt_wr = 1'b0;
    is_nowr  = 1'b0;
    ovf_chk  = 1'b0;
    if (opcode == 6'h00) begin
      is_hilo = (funct >= 6'h18) && (funct <= 6'h1B);
      case (funct)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B: is_rd_wr = 1'b1;
        default:      is_rd_wr = 1'b0;
      endcase
      ovf_chk = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h1A);
    end else begin
      is_rt_wr = (opcode >= 6'h08) && (opcode <= 6'h0E);
      is_nowr  = (opcode == 6'h04) || (opcode == 6'h05) ||
                 (opcode == 6'h23) || (opcode == 6'h2B);
      ovf_chk  = (opcode == 6'h08);
    end
    is_legal = is_hilo | is_rd_wr | is_rt_wr | is_nowr;
    trap     = ovf_chk && alu_overflow;
    rf_waddr = is_rd_wr ? rd : rt;
    rf_we    = (state_reg == WB) && (is_rd_wr || is_rt_wr) && !trap &&
               (rf_waddr != 5'd0);
  end

  // Next-state logic and the status outputs that are qualified by state.
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    done        = 1'b0;
    ovf_trap    = 1'b0;
    illegal     = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = ISSUE;
      end
      ISSUE: state_next = WB;
      WB: begin
        state_next = IDLE;
        done       = 1'b1;
        ovf_trap   = trap;
        illegal    = !is_legal;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand capture at accept. A debug write on the same edge is forwarded, so
  // the operands already show the new value; register 0 always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_instr <= '0;
      alu_gr1   <= '0;
      alu_gr2   <= '0;
    end else if (accept) begin
      alu_instr <= instr;
      if (in_rs == 5'd0)                       alu_gr1 <= '0;
      else if (dbg_wr_ok && dbg_waddr == in_rs) alu_gr1 <= dbg_wdata;
      else                                      alu_gr1 <= rf[in_rs];
      if (in_rt == 5'd0)                       alu_gr2 <= '0;
      else if (dbg_wr_ok && dbg_waddr == in_rt) alu_gr2 <= dbg_wdata;
      else                                      alu_gr2 <= rf[in_rt];
    end
  end

  // Register file. Debug writes happen only in IDLE and writeback only in WB,
  // so the two never meet; a write that targets register 0 is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (dbg_wr_ok) begin
      rf[dbg_waddr] <= dbg_wdata;
    end else if (rf_we) begin
      rf[rf_waddr] <= alu_c;
    end
  end

  // HI/LO writeback for the multiply/divide group; an overflowing div is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_reg == WB) && is_hilo && !trap) begin
      hi_q <= alu_hi;
      lo_q <= alu_lo;
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Table-driven bench for alu_issue_wb, with a small behavioural ALU model.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] alu_instr, alu_gr1, alu_gr2;
  logic [31:0] alu_c, alu_hi, alu_lo;
  logic        alu_zero, alu_negative, alu_overflow;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_waddr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [31:0] hi_q, lo_q;
  logic        done, ovf_trap, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_instr(alu_instr), .alu_gr1(alu_gr1), .alu_gr2(alu_gr2),
    .alu_c(alu_c), .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .dbg_we(dbg_we),
    .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .hi_q(hi_q), .lo_q(lo_q), .done(done),
    .ovf_trap(ovf_trap), .illegal(illegal)
  );

  // Behavioural ALU covering the operations used below.
  logic [5:0]  m_op, m_fn;
  logic [31:0] m_simm, m_zimm;
  logic [63:0] m_prod;
  always_comb begin
    m_op   = alu_instr[31:26];
    m_fn   = alu_instr[5:0];
    m_simm = {{16{alu_instr[15]}}, alu_instr[15:0]};
    m_zimm = {16'h0, alu_instr[15:0]};
    m_prod = '0;
    alu_c = '0; alu_hi = '0; alu_lo = '0; alu_overflow = 1'b0;
    if (m_op == 6'h00) begin
      case (m_fn)
        6'h20: begin
          alu_c = alu_gr1 + alu_gr2;
          alu_overflow = (alu_gr1[31] == alu_gr2[31]) && (alu_c[31] != alu_gr1[31]);
        end
        6'h21: alu_c = alu_gr1 + alu_gr2;
        6'h22: begin
          alu_c = alu_gr1 - alu_gr2;
          alu_overflow = (alu_gr1[31] != alu_gr2[31]) && (alu_c[31] != alu_gr1[31]);
        end
        6'h24: alu_c = alu_gr1 & alu_gr2;
        6'h25: alu_c = alu_gr1 | alu_gr2;
        6'h2A: alu_c = {31'd0, $signed(alu_gr1) < $signed(alu_gr2)};
        6'h18: begin
          m_prod = $signed({{32{alu_gr1[31]}}, alu_gr1}) * $signed({{32{alu_gr2[31]}}, alu_gr2});
          alu_hi = m_prod[63:32]; alu_lo = m_prod[31:0];
        end
        6'h1A: alu_overflow = (alu_gr1 == 32'h8000_0000) && (alu_gr2 == 32'hFFFF_FFFF);
        6'h1B: if (alu_gr2 != 0) begin
          alu_lo = alu_gr1 / alu_gr2; alu_hi = alu_gr1 % alu_gr2;
        end
        default: alu_c = '0;
      endcase
    end else begin
      case (m_op)
        6'h08: begin
          alu_c = alu_gr1 + m_simm;
          alu_overflow = (alu_gr1[31] == m_simm[31]) && (alu_c[31] != alu_gr1[31]);
        end
        6'h0D: alu_c = alu_gr1 | m_zimm;
        6'h23: alu_c = alu_gr1 + m_simm;
        default: alu_c = '0;
      endcase
    end
    alu_zero     = (alu_gr1 == alu_gr2);
    alu_negative = alu_c[31];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    dbg_raddr = a;
    #1 d = dbg_rdata;
  endtask

  // Issue one word starting from IDLE. Optionally a debug write goes on the
  // accept edge (dw_acc) or during ISSUE (dw_iss). The task samples the
  // operands in ISSUE and the status pulses in WB, checks the latency, and
  // returns after the writeback edge.
  task automatic issue(input string nm, input logic [31:0] w,
                       input bit dw_acc, input bit dw_iss,
                       input logic [4:0] dwa, input logic [31:0] dwd,
                       output logic [31:0] g1, output logic [31:0] g2,
                       output logic [2:0] st);
    @(negedge clk);
    chk({nm, " ready_idle"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr = w;
    if (dw_acc) begin dbg_we = 1'b1; dbg_waddr = dwa; dbg_wdata = dwd; end
    @(negedge clk);
    instr_valid = 1'b0; dbg_we = 1'b0;
    chk({nm, " ready_issue"}, {31'd0, instr_ready}, 32'd0);
    chk({nm, " done_n+1"}, {31'd0, done}, 32'd0);
    g1 = alu_gr1; g2 = alu_gr2;
    if (dw_iss) begin dbg_we = 1'b1; dbg_waddr = dwa; dbg_wdata = dwd; end
    @(negedge clk);
    dbg_we = 1'b0;
    chk({nm, " instr_hold"}, alu_instr, w);
    st = {done, ovf_trap, illegal};
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;        // preload RF[3]
    logic [31:0] b;        // preload RF[2]
    logic [31:0] w;
    logic [31:0] e_gr1;
    logic [31:0] e_gr2;
    logic [2:0]  e_st;     // {done, ovf_trap, illegal}
    logic [4:0]  c_reg;
    logic [31:0] c_val;
    bit          c_hilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] g1, g2, r;
    logic [2:0]  st;

    vecs[0]  = '{"add",      32'h1,        32'h8,        32'h00620820, 32'h1,        32'h8,        3'b100, 5'd1, 32'h9,        1'b0, 32'h0, 32'h0};
    vecs[1]  = '{"add_ovf",  32'h7FFFFFFF, 32'h8,        32'h00620820, 32'h7FFFFFFF, 32'h8,        3'b110, 5'd1, 32'h0,        1'b0, 32'h0, 32'h0};
    vecs[2]  = '{"addu",     32'h7FFFFFFF, 32'h8,        32'h00620821, 32'h7FFFFFFF, 32'h8,        3'b100, 5'd1, 32'h80000007, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{"mult",     32'h00FFFFFF, 32'h00FFFFFF, 32'h00620018, 32'h00FFFFFF, 32'h00FFFFFF, 3'b100, 5'd1, 32'h0,        1'b1, 32'h0000FFFF, 32'hFE000001};
    vecs[4]  = '{"divu",     32'd17,       32'd5,        32'h0062001B, 32'd17,       32'd5,        3'b100, 5'd1, 32'h0,        1'b1, 32'd2, 32'd3};
    vecs[5]  = '{"addi_r0",  32'h7,        32'h5,        32'h20600008, 32'h7,        32'h0,        3'b100, 5'd0, 32'h0,        1'b0, 32'h0, 32'h0};
    vecs[6]  = '{"beq",      32'h3,        32'h3,        32'h10620004, 32'h3,        32'h3,        3'b100, 5'd1, 32'h0,        1'b0, 32'h0, 32'h0};
    vecs[7]  = '{"op3f",     32'h4,        32'h6,        32'hFC620000, 32'h4,        32'h6,        3'b101, 5'd1, 32'h0,        1'b0, 32'h0, 32'h0};
    vecs[8]  = '{"sub",      32'd10,       32'd3,        32'h00620822, 32'd10,       32'd3,        3'b100, 5'd1, 32'd7,        1'b0, 32'h0, 32'h0};
    vecs[9]  = '{"and",      32'hF0F0,     32'hFF00,     32'h00620824, 32'hF0F0,     32'hFF00,     3'b100, 5'd1, 32'hF000,     1'b0, 32'h0, 32'h0};
    vecs[10] = '{"addi_rt",  32'd5,        32'd9,        32'h2061FFFF, 32'd5,        32'h0,        3'b100, 5'd1, 32'd4,        1'b0, 32'h0, 32'h0};
    vecs[11] = '{"ori",      32'h0F,       32'd9,        32'h346100F0, 32'h0F,       32'h0,        3'b100, 5'd1, 32'hFF,       1'b0, 32'h0, 32'h0};
    vecs[12] = '{"lw_nowr",  32'h100,      32'd9,        32'h8C610004, 32'h100,      32'h0,        3'b100, 5'd1, 32'h0,        1'b0, 32'h0, 32'h0};
    vecs[13] = '{"slt",      32'hFFFFFFFF, 32'd1,        32'h0062082A, 32'hFFFFFFFF, 32'd1,        3'b100, 5'd1, 32'd1,        1'b0, 32'h0, 32'h0};

    // Reset state
    #12;
    chk("rst done",      {29'd0, done, ovf_trap, illegal}, 32'd0);
    chk("rst alu_instr", alu_instr, 32'd0);
    chk("rst gr1",       alu_gr1, 32'd0);
    chk("rst gr2",       alu_gr2, 32'd0);
    chk("rst hi",        hi_q, 32'd0);
    chk("rst lo",        lo_q, 32'd0);
    rd_reg(5'd5, r);
    chk("rst rf5", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after rst", {31'd0, instr_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      dbg_write(5'd3, vecs[i].a);
      dbg_write(5'd2, vecs[i].b);
      dbg_write(5'd1, 32'd0);
      issue(vecs[i].name, vecs[i].w, 1'b0, 1'b0, 5'd0, 32'd0, g1, g2, st);
      chk({vecs[i].name, " gr1"}, g1, vecs[i].e_gr1);
      chk({vecs[i].name, " gr2"}, g2, vecs[i].e_gr2);
      chk({vecs[i].name, " status"}, {29'd0, st}, {29'd0, vecs[i].e_st});
      rd_reg(vecs[i].c_reg, r);
      chk({vecs[i].name, " rf"}, r, vecs[i].c_val);
      rd_reg(5'd3, r);
      chk({vecs[i].name, " rf3 kept"}, r, vecs[i].a);
      if (vecs[i].c_hilo) begin
        chk({vecs[i].name, " hi"}, hi_q, vecs[i].e_hi);
        chk({vecs[i].name, " lo"}, lo_q, vecs[i].e_lo);
      end
      $display("vec %0d %s instr=%h gr1=%h gr2=%h st=%b", i, vecs[i].name, vecs[i].w, g1, g2, st);
    end

    // A debug write on the accept edge is forwarded into the operands
    dbg_write(5'd2, 32'd0);
    dbg_write(5'd4, 32'h11);
    issue("fwd", 32'h00620820, 1'b1, 1'b0, 5'd3, 32'h55, g1, g2, st);
    chk("fwd gr1", g1, 32'h55);
    rd_reg(5'd1, r);
    chk("fwd rf1", r, 32'h55);
    $display("seq fwd gr1=%h rf1=%h", g1, r);

    // A debug write during ISSUE is ignored
    issue("dbg_iss", 32'h00620821, 1'b0, 1'b1, 5'd4, 32'hAA, g1, g2, st);
    rd_reg(5'd4, r);
    chk("dbg_iss rf4", r, 32'h11);
    $display("seq dbg_iss rf4=%h", r);

    // Back-to-back issue with a RAW dependency and no stall
    dbg_write(5'd3, 32'd7);
    issue("b2b_1", 32'h20620008, 1'b0, 1'b0, 5'd0, 32'd0, g1, g2, st);
    issue("b2b_2", 32'h00420820, 1'b0, 1'b0, 5'd0, 32'd0, g1, g2, st);
    chk("b2b gr1", g1, 32'd15);
    chk("b2b gr2", g2, 32'd15);
    rd_reg(5'd1, r);
    chk("b2b rf1", r, 32'd30);
    $display("seq b2b gr1=%h gr2=%h rf1=%h", g1, g2, r);

    // Reset asserted in ISSUE aborts the instruction
    @(negedge clk);
    instr_valid = 1'b1; instr = 32'h00620821;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort in_issue", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort status", {29'd0, done, ovf_trap, illegal}, 32'd0);
    chk("abort state_idle", {31'd0, instr_ready}, 32'd1);
    chk("abort alu_instr", alu_instr, 32'd0);
    chk("abort gr1", alu_gr1 | alu_gr2, 32'd0);
    chk("abort hilo", hi_q | lo_q, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort no_done", {31'd0, done}, 32'd0);
    end
    rd_reg(5'd1, r);
    chk("abort rf1", r, 32'd0);
    $display("seq abort rf1=%h ready=%b", r, instr_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr_ready  out  1  block can accept an instruction.
REQ-006 instr  in  32  MIPS instruction word.
REQ-007 alu_instr  out  32  instruction presented to the ALU (i_datain).
REQ-008 alu_gr1 / alu_gr2  out  32 each  operands RF[rs] / RF[rt] presented to the ALU.
REQ-009 alu_c, alu_hi, alu_lo  in  32 each  ALU result, HI and LO.
REQ-010 alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags.
REQ-011 dbg_we, dbg_waddr[4:0], dbg_wdata[31:0]  in  register-file preload port.
REQ-012 dbg_raddr[4:0]  in; dbg_rdata[31:0]  out  combinational register-file read.
REQ-013 hi_q, lo_q  out  32 each  architectural HI/LO registers.
REQ-014 done, ovf_trap, illegal  out  1 each  single-cycle completion/status pulses.

Function
REQ-015 FSM SHALL have the states IDLE, ISSUE and WB, with the transitions IDLE->ISSUE on instr_valid&instr_ready, ISSUE->WB unconditionally, and WB->IDLE unconditionally.
REQ-016 instr_ready SHALL be 1 only in IDLE; accept SHALL latch instr.
REQ-017 On the IDLE->ISSUE edge, alu_instr, alu_gr1 and alu_gr2 SHALL register the latched word, RF[rs] and RF[rt], and SHALL hold those values through WB.
REQ-018 Writeback SHALL occur on the WB->IDLE edge; done SHALL be high during the WB cycle; latency SHALL be accept edge N -> done high in cycle N+2; throughput SHALL be 1 instruction per 3 cycles.
REQ-019 For R-type (opcode 0x00) instructions with funct 0x18-0x1B (mult/multu/div/divu), the block SHALL write alu_hi to hi_q and alu_lo to lo_q and SHALL NOT write the register file.
REQ-020 For R-type instructions with funct in {0x00,0x02,0x03,0x04,0x06,0x07,0x20-0x27,0x2A,0x2B}, the block SHALL write alu_c to RF[rd].
REQ-021 For opcodes 0x08-0x0E, the block SHALL write alu_c to RF[rt].
REQ-022 For opcodes 0x04, 0x05, 0x23 and 0x2B, the block SHALL NOT write the register file or HI/LO.
REQ-023 For add (funct 0x20), sub (funct 0x22), addi (opcode 0x08) and div (funct 0x1A), when alu_overflow=1 in WB the block SHALL suppress the write and pulse ovf_trap in WB.
REQ-024 For any other opcode/funct, the block SHALL perform no write and SHALL pulse illegal with done in WB.
REQ-025 Writes to RF[0] SHALL be discarded; reads of RF[0], including alu_gr1, alu_gr2 and dbg_rdata, SHALL return 0.
REQ-026 dbg_we SHALL be honoured only in IDLE and ignored in ISSUE and WB.
REQ-027 When dbg_we and an instruction accept occur on the same IDLE edge, the debug write SHALL complete first, so that alu_gr1/alu_gr2 show the new value.
REQ-028 A WB write to a register SHALL be visible to an instruction accepted on the next edge, with no hazard stall.
REQ-029 All arithmetic SHALL be performed by the ALU; the block SHALL only route 32-bit values without extension.

Reset
REQ-030 While rst_n=0, FSM SHALL be IDLE; RF[0..31], hi_q, lo_q, alu_instr, alu_gr1 and alu_gr2 SHALL be 0; done, ovf_trap and illegal SHALL be 0; instr_ready SHALL be 1 after release.
REQ-031 Reset asserted in ISSUE or WB SHALL abort the instruction with no writeback and no pulse.

Verification
REQ-032 Preload RF[3]=1, RF[2]=8; issue 0x00620820 (add $1,$3,$2) with ALU model -> alu_gr1=1, alu_gr2=8, done in cycle N+2, dbg_raddr=1 reads 9.
REQ-033 RF[3]=0x7FFFFFFF, RF[2]=8, add -> ovf_trap=1, RF[1] unchanged (0); the same case with addu (funct 0x21) -> RF[1]=0x80000007.
REQ-034 RF[3]=0x00FFFFFF, RF[2]=0x00FFFFFF, mult (funct 0x18) -> hi_q=0x0000FFFF, lo_q=0xFE000001, RF unchanged.
REQ-035 addi $0,$3,8 with RF[3]=7 -> no change; dbg_raddr=0 reads 0; beq with RF[3]=RF[2]=3 -> done, no writes; opcode 0x3F -> illegal pulse.
REQ-036 Back-to-back instructions: addi $2,$3,8 followed immediately by add $1,$2,$2 -> second sees alu_gr1=RF[2]=15; rst_n pulled low in ISSUE of a third instruction -> no write, state IDLE, all outputs 0.
